tri_burst_ctrl: RTL and testbench

Controller that sequences the 12-bit triangular-wave datapath as programmable bursts. It accepts a configuration (step, peak, sample divider, period count) over a valid/ready handshake and runs rise/fall sweeps on start. It emits one sample strobe per divided tick and reports period and burst completion. It sits between the control/register side and the DAC sample path.

---
 rtl/tri_pkg.sv | 21 ++
 rtl/tri_step_core.sv | 48 ++++
 rtl/tri_burst_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_tri_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared types and reset-default constants for the triangular burst controller.
package tri_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int DIV_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int   DEF_STEP      = 1;
    localparam int   DEF_DIV       = 0;
    localparam int   DEF_PERIODS   = 1;
    // The default peak is full scale, so it is expressed as a fill bit at any width.
    localparam logic DEF_PEAK_FILL = 1'b1;

endpackage

// File: rtl/tri_step_core.sv
// Accumulator datapath: steps up toward peak or down toward zero on each tick.
module tri_step_core
    import tri_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              tick,
    input  logic              dir,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] peak,
    output logic [DATA_W-1:0] acc,
    output logic              hit_peak,
    output logic              hit_zero
);

    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] acc_r;

    assign acc = acc_r;

    // Peak and zero detection; the sum carries an extra bit so it cannot wrap.
    always_comb begin
        sum_s    = {1'b0, acc_r} + {1'b0, step};
        hit_peak = (sum_s >= {1'b0, peak});
        hit_zero = (acc_r <= step);
    end

    // Accumulator register: clear wins over tick, clamps at peak and zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            acc_r <= {DATA_W{1'b0}};
        end else if (tick) begin
            if (dir) begin
                acc_r <= hit_peak ? peak : sum_s[DATA_W-1:0];
            end else begin
                acc_r <= hit_zero ? {DATA_W{1'b0}} : (acc_r - step);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/tri_burst_ctrl.sv
// Burst sequencer for the triangular-wave datapath: config shadow, prescaler,
// rise/fall FSM, period counting and registered strobes.
module tri_burst_ctrl
    import tri_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [DATA_W-1:0] cfg_peak,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_periods,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              period_tick,
    output logic              done
);

    state_t            state_r;
    state_t            next_state_s;

    logic [DATA_W-1:0] step_r;
    logic [DATA_W-1:0] peak_r;
    logic [DIV_W-1:0]  div_r;
    logic [CNT_W-1:0]  periods_r;
    logic [DIV_W-1:0]  presc_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              cfg_ready_r;
    logic              cfg_err_r;
    logic              busy_r;
    logic              sample_valid_r;
    logic              period_tick_r;
    logic              done_r;

    logic              cfg_fire_s;
    logic              cfg_legal_s;
    logic              start_go_s;
    logic              running_s;
    logic              tick_s;
    logic              hit_peak_s;
    logic              hit_zero_s;
    logic              period_end_s;
    logic              last_period_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    logic              cfg_ready_nxt_s;
    logic              cfg_err_nxt_s;
    logic              busy_nxt_s;
    logic              sample_valid_nxt_s;
    logic              period_tick_nxt_s;
    logic              done_nxt_s;

    // Handshake, tick and period-completion qualifiers; abort masks them all.
    always_comb begin
        cfg_legal_s   = (cfg_step != {DATA_W{1'b0}}) &&
                        (cfg_peak != {DATA_W{1'b0}}) &&
                        (cfg_step <= cfg_peak);
        cfg_fire_s    = cfg_valid && cfg_ready_r && (state_r == ST_IDLE) && !abort;
        start_go_s    = (state_r == ST_IDLE) && start && !abort;
        running_s     = (state_r == ST_RISE) || (state_r == ST_FALL);
        tick_s        = running_s && (presc_r == div_r) && !abort;
        period_end_s  = (state_r == ST_FALL) && tick_s && hit_zero_s;
        cnt_inc_s     = cnt_r + CNT_W'(1);
        last_period_s = (periods_r != {CNT_W{1'b0}}) && (cnt_inc_s == periods_r);
    end

    tri_step_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort || start_go_s),
        .tick     (tick_s),
        .dir      (state_r == ST_RISE),
        .step     (step_r),
        .peak     (peak_r),
        .acc      (sample),
        .hit_peak (hit_peak_s),
        .hit_zero (hit_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_go_s) begin
                        next_state_s = ST_RISE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RISE: begin
                    if (tick_s && hit_peak_s) begin
                        next_state_s = ST_FALL;
                    end else begin
                        next_state_s = ST_RISE;
                    end
                end
                ST_FALL: begin
                    if (period_end_s) begin
                        next_state_s = last_period_s ? ST_DONE : ST_RISE;
                    end else begin
                        next_state_s = ST_FALL;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; status follows the next state so it lines up with it.
    always_comb begin
        busy_nxt_s         = (next_state_s == ST_RISE) || (next_state_s == ST_FALL);
        cfg_ready_nxt_s    = (next_state_s == ST_IDLE);
        cfg_err_nxt_s      = cfg_fire_s && !cfg_legal_s;
        sample_valid_nxt_s = tick_s;
        period_tick_nxt_s  = period_end_s;
        done_nxt_s         = period_end_s && last_period_s;
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_r    <= 1'b0;
            cfg_err_r      <= 1'b0;
            busy_r         <= 1'b0;
            sample_valid_r <= 1'b0;
            period_tick_r  <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            cfg_ready_r    <= cfg_ready_nxt_s;
            cfg_err_r      <= cfg_err_nxt_s;
            busy_r         <= busy_nxt_s;
            sample_valid_r <= sample_valid_nxt_s;
            period_tick_r  <= period_tick_nxt_s;
            done_r         <= done_nxt_s;
        end
    end

    assign cfg_ready    = cfg_ready_r;
    assign cfg_err      = cfg_err_r;
    assign busy         = busy_r;
    assign sample_valid = sample_valid_r;
    assign period_tick  = period_tick_r;
    assign done         = done_r;

    // Config shadow; a rejected offer leaves the previous config in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_r    <= DATA_W'(DEF_STEP);
            peak_r    <= {DATA_W{DEF_PEAK_FILL}};
            div_r     <= DIV_W'(DEF_DIV);
            periods_r <= CNT_W'(DEF_PERIODS);
        end else if (cfg_fire_s && cfg_legal_s) begin
            step_r    <= cfg_step;
            peak_r    <= cfg_peak;
            div_r     <= cfg_div;
            periods_r <= cfg_periods;
        end else begin
            step_r    <= step_r;
            peak_r    <= peak_r;
            div_r     <= div_r;
            periods_r <= periods_r;
        end
    end

    // Sample prescaler and period counter, both restarted on burst entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r <= {DIV_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (abort || start_go_s) begin
            presc_r <= {DIV_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (running_s) begin
            presc_r <= tick_s ? {DIV_W{1'b0}} : (presc_r + DIV_W'(1));
            cnt_r   <= period_end_s ? cnt_inc_s : cnt_r;
        end else begin
            presc_r <= presc_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: tb/tb_tri_burst_ctrl.sv
// Directed testbench for tri_burst_ctrl with hand-computed sample sequences.
module tb_tri_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_step;
    logic [11:0] cfg_peak;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_periods;
    logic        cfg_err;
    logic        start;
    logic        abort;
    logic        busy;
    logic [11:0] sample;
    logic        sample_valid;
    logic        period_tick;
    logic        done;

    int checks = 0;
    int errors = 0;

    int cap_val[$];
    int cap_gap[$];
    bit cap_pt[$];
    bit cap_done[$];
    int cap_pt_total;
    int cap_done_total;
    bit cap_timeout;

    always #5 clk = ~clk;

    tri_burst_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_step     (cfg_step),
        .cfg_peak     (cfg_peak),
        .cfg_div      (cfg_div),
        .cfg_periods  (cfg_periods),
        .cfg_err      (cfg_err),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_tick  (period_tick),
        .done         (done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int s, input int p, input int d, input int n);
        cfg_step    = 12'(s);
        cfg_peak    = 12'(p);
        cfg_div     = 16'(d);
        cfg_periods = 8'(n);
        cfg_valid   = 1'b1;
        cyc();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    // Records strobed samples and the cycle gap before each; no comparisons here.
    task automatic collect(input int n, input int budget);
        int gap  = 0;
        int used = 0;
        cap_val.delete();
        cap_gap.delete();
        cap_pt.delete();
        cap_done.delete();
        cap_pt_total   = 0;
        cap_done_total = 0;
        cap_timeout    = 1'b0;
        while (cap_val.size() < n) begin
            if (used >= budget) begin
                cap_timeout = 1'b1;
                break;
            end
            cyc();
            used++;
            gap++;
            if (period_tick) cap_pt_total++;
            if (done) cap_done_total++;
            if (sample_valid) begin
                cap_val.push_back(int'(sample));
                cap_gap.push_back(gap);
                cap_pt.push_back(period_tick);
                cap_done.push_back(done);
                gap = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (sample !== 12'd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", sample); end
        checks++; if ({sample_valid, period_tick, done, cfg_err, busy, cfg_ready} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {sample_valid, period_tick, done, cfg_err, busy, cfg_ready});
        end
        rst_n = 1'b1;
        cyc();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_single_period();
        int exp_s[6] = '{4, 8, 12, 8, 4, 0};
        offer(4, 12, 0, 1);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL single_cfg_err: got %b expected 0", cfg_err); end
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        collect(6, 20);
        checks++; if (cap_val.size() !== 6) begin errors++; $display("FAIL single_count: got %0d expected 6", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== exp_s[i]) begin errors++; $display("FAIL single_sample[%0d]: got %0d expected %0d", i, cap_val[i], exp_s[i]); end
            checks++; if (cap_gap[i] !== 1) begin errors++; $display("FAIL single_gap[%0d]: got %0d expected 1", i, cap_gap[i]); end
            checks++; if (cap_pt[i] !== (i == 5)) begin errors++; $display("FAIL single_pt[%0d]: got %b expected %b", i, cap_pt[i], (i == 5)); end
            checks++; if (cap_done[i] !== (i == 5)) begin errors++; $display("FAIL single_done[%0d]: got %b expected %b", i, cap_done[i], (i == 5)); end
        end
        checks++; if ({busy, cfg_ready} !== 2'b00) begin errors++; $display("FAIL single_done_state: got busy/ready %b expected 00", {busy, cfg_ready}); end
        cyc();
        checks++; if ({busy, cfg_ready} !== 2'b01) begin errors++; $display("FAIL single_idle_state: got busy/ready %b expected 01", {busy, cfg_ready}); end
        checks++; if (sample !== 12'd0) begin errors++; $display("FAIL single_hold: got %0d expected 0", sample); end
    endtask

    task automatic test_two_periods_div();
        int exp_s[6] = '{5, 10, 12, 7, 2, 0};
        offer(5, 12, 2, 2);
        do_start();
        collect(12, 60);
        checks++; if (cap_val.size() !== 12) begin errors++; $display("FAIL div_count: got %0d expected 12", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== exp_s[i % 6]) begin errors++; $display("FAIL div_sample[%0d]: got %0d expected %0d", i, cap_val[i], exp_s[i % 6]); end
            checks++; if (cap_gap[i] !== 3) begin errors++; $display("FAIL div_gap[%0d]: got %0d expected 3", i, cap_gap[i]); end
            checks++; if (cap_pt[i] !== (i % 6 == 5)) begin errors++; $display("FAIL div_pt[%0d]: got %b expected %b", i, cap_pt[i], (i % 6 == 5)); end
            checks++; if (cap_done[i] !== (i == 11)) begin errors++; $display("FAIL div_done[%0d]: got %b expected %b", i, cap_done[i], (i == 11)); end
        end
        checks++; if (cap_pt_total !== 2) begin errors++; $display("FAIL div_pt_total: got %0d expected 2", cap_pt_total); end
        checks++; if (cap_done_total !== 1) begin errors++; $display("FAIL div_done_total: got %0d expected 1", cap_done_total); end
        cyc();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div_ready_after: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_cfg_reject();
        int exp_s[4] = '{3, 6, 3, 0};
        offer(3, 6, 0, 1);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_good_err: got %b expected 0", cfg_err); end
        offer(13, 12, 0, 1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_step_gt_peak: got %b expected 1", cfg_err); end
        cyc();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_pulse_width: got %b expected 0", cfg_err); end
        offer(0, 5, 0, 1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_zero_step: got %b expected 1", cfg_err); end
        offer(1, 0, 0, 1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_zero_peak: got %b expected 1", cfg_err); end
        do_start();
        collect(4, 20);
        checks++; if (cap_val.size() !== 4) begin errors++; $display("FAIL rej_count: got %0d expected 4", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== exp_s[i]) begin errors++; $display("FAIL rej_sample[%0d]: got %0d expected %0d", i, cap_val[i], exp_s[i]); end
        end
        checks++; if (cap_done_total !== 1) begin errors++; $display("FAIL rej_done: got %0d expected 1", cap_done_total); end
        cyc();
    endtask

    task automatic test_cfg_with_start();
        int exp_s[4] = '{2, 4, 2, 0};
        cfg_step = 12'd2; cfg_peak = 12'd4; cfg_div = 16'd0; cfg_periods = 8'd1;
        cfg_valid = 1'b1;
        start = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        start = 1'b0;
        checks++; if ({cfg_err, busy} !== 2'b01) begin errors++; $display("FAIL same_err_busy: got %b expected 01", {cfg_err, busy}); end
        collect(4, 20);
        checks++; if (cap_val.size() !== 4) begin errors++; $display("FAIL same_count: got %0d expected 4", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== exp_s[i]) begin errors++; $display("FAIL same_sample[%0d]: got %0d expected %0d", i, cap_val[i], exp_s[i]); end
            checks++; if (cap_done[i] !== (i == 3)) begin errors++; $display("FAIL same_done[%0d]: got %b expected %b", i, cap_done[i], (i == 3)); end
        end
        cyc();
    endtask

    task automatic test_abort();
        bit stray = 1'b0;
        offer(1, 100, 0, 0);
        do_start();
        collect(10, 20);
        checks++; if (cap_val.size() !== 10) begin errors++; $display("FAIL abort_count: got %0d expected 10", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== i + 1) begin errors++; $display("FAIL abort_sample[%0d]: got %0d expected %0d", i, cap_val[i], i + 1); end
        end
        do_abort();
        checks++; if ({busy, sample_valid, period_tick, done} !== 4'b0) begin
            errors++; $display("FAIL abort_flags: got %b expected 0000", {busy, sample_valid, period_tick, done});
        end
        checks++; if (sample !== 12'd0) begin errors++; $display("FAIL abort_sample_clr: got %0d expected 0", sample); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", cfg_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (done || period_tick) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL abort_stray_strobe: got %b expected 0", stray); end
        // A legal config offered alongside abort must be ignored.
        cfg_step = 12'd9; cfg_peak = 12'd9; cfg_div = 16'd0; cfg_periods = 8'd1;
        cfg_valid = 1'b1;
        abort = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        abort = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_cfg_err: got %b expected 0", cfg_err); end
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart_busy: got %b expected 1", busy); end
        collect(2, 10);
        checks++; if (cap_val.size() !== 2) begin errors++; $display("FAIL abort_restart_count: got %0d expected 2", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== i + 1) begin errors++; $display("FAIL abort_restart_sample[%0d]: got %0d expected %0d", i, cap_val[i], i + 1); end
        end
        do_abort();
    endtask

    task automatic test_reset_mid_burst();
        int exp_s[4] = '{4, 8, 12, 8};
        offer(4, 12, 0, 1);
        do_start();
        collect(4, 20);
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== exp_s[i]) begin errors++; $display("FAIL rstmid_pre[%0d]: got %0d expected %0d", i, cap_val[i], exp_s[i]); end
        end
        rst_n = 1'b0;
        cyc();
        checks++; if (sample !== 12'd0) begin errors++; $display("FAIL rstmid_sample: got %0d expected 0", sample); end
        checks++; if ({sample_valid, period_tick, done, cfg_err, busy, cfg_ready} !== 6'b0) begin
            errors++; $display("FAIL rstmid_flags: got %b expected 000000", {sample_valid, period_tick, done, cfg_err, busy, cfg_ready});
        end
        rst_n = 1'b1;
        cyc();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cfg_ready); end
        do_start();
        collect(3, 10);
        checks++; if (cap_val.size() !== 3) begin errors++; $display("FAIL rstmid_count: got %0d expected 3", cap_val.size()); end
        for (int i = 0; i < cap_val.size(); i++) begin
            checks++; if (cap_val[i] !== i + 1) begin errors++; $display("FAIL rstmid_default[%0d]: got %0d expected %0d", i, cap_val[i], i + 1); end
            checks++; if (cap_gap[i] !== 1) begin errors++; $display("FAIL rstmid_gap[%0d]: got %0d expected 1", i, cap_gap[i]); end
        end
        do_abort();
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_step    = 12'd0;
        cfg_peak    = 12'd0;
        cfg_div     = 16'd0;
        cfg_periods = 8'd0;
        start       = 1'b0;
        abort       = 1'b0;
        test_reset();
        test_single_period();
        test_two_periods_div();
        test_cfg_reject();
        test_cfg_with_start();
        test_abort();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
